// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception unit: cause codes,
// c0 register indices, STATUS/CAUSE bit positions and the default vector.
package cp0_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'b000,
    CAUSE_OVF  = 3'b001,
    CAUSE_PRIV = 3'b010,
    CAUSE_ILL  = 3'b011,
    CAUSE_IRQ  = 3'b100,
    CAUSE_TMR  = 3'b101,
    CAUSE_DBL  = 3'b110
  } cause_e;

  localparam logic [4:0] C0_STATUS   = 5'd0;
  localparam logic [4:0] C0_CAUSE    = 5'd1;
  localparam logic [4:0] C0_EPC      = 5'd2;
  localparam logic [4:0] C0_COUNT    = 5'd3;
  localparam logic [4:0] C0_COMPARE  = 5'd4;
  localparam logic [4:0] C0_SCRATCH0 = 5'd5;
  localparam logic [4:0] C0_SCRATCH1 = 5'd6;

  localparam int STATUS_KM      = 0;
  localparam int STATUS_IE      = 1;
  localparam int CAUSE_IRQ_PEND = 8;
  localparam int CAUSE_TMR_PEND = 9;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer bringing the asynchronous external irq level
// into the clk domain.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq,
  output logic irq_s
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: privilege state, exception/interrupt arbitration at
// instruction boundaries, timer and the software-visible c0 registers.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] EXC_VECTOR  = DATA_W'(EXC_VECTOR_DEF),
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic              cause_write,
  input  logic [2:0]        int_cause,
  input  logic              exit_kernel,
  input  logic              write_c0,
  input  logic [4:0]        c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              irq,
  output logic              irq_ack,
  output logic              kernel_mode,
  output logic              exc_taken,
  output logic [DATA_W-1:0] exc_vector,
  output logic [DATA_W-1:0] epc,
  output logic              halt
);

  logic              km_q, km_d;
  logic              ie_q, ie_d;
  cause_e            code_q, code_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic [DATA_W-1:0] scratch0_q, scratch0_d;
  logic [DATA_W-1:0] scratch1_q, scratch1_d;
  logic              tmr_pend_q, tmr_pend_d;
  logic              halt_q, halt_d;

  logic irq_pend;
  logic active, sync_exc, dbl_fault, irq_take, tmr_take, do_exit, do_write;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq),
    .irq_s   (irq_pend)
  );

  // Strict priority: only the highest-ranked event of the cycle acts.
  always_comb begin
    active    = instr_valid && !halt_q;
    sync_exc  = active && cause_write && !km_q;
    dbl_fault = active && cause_write && km_q;
    irq_take  = active && !cause_write && irq_pend && ie_q && !km_q;
    tmr_take  = active && !cause_write && !irq_take && tmr_pend_q && ie_q && !km_q;
    do_exit   = active && !cause_write && !irq_take && !tmr_take && exit_kernel && km_q;
    do_write  = active && !cause_write && !irq_take && !tmr_take && !do_exit
                && write_c0 && km_q;
  end

  always_comb begin
    km_d       = km_q;
    ie_d       = ie_q;
    code_d     = code_q;
    epc_d      = epc_q;
    count_d    = count_q + 1'b1;
    compare_d  = compare_q;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    tmr_pend_d = tmr_pend_q;
    halt_d     = halt_q;

    if (!halt_q && (count_q == compare_q) && (compare_q != '0)) begin
      tmr_pend_d = 1'b1;
    end

    if (do_write) begin
      case (c0_addr)
        C0_STATUS: begin
          km_d = c0_wdata[STATUS_KM];
          ie_d = c0_wdata[STATUS_IE];
        end
        C0_EPC:      epc_d = c0_wdata;
        C0_COUNT:    count_d = c0_wdata;
        C0_COMPARE: begin
          compare_d  = c0_wdata;
          tmr_pend_d = 1'b0;
        end
        C0_SCRATCH0: scratch0_d = c0_wdata;
        C0_SCRATCH1: scratch1_d = c0_wdata;
        default: ;
      endcase
    end

    if (sync_exc || irq_take || tmr_take) begin
      epc_d  = pc;
      code_d = sync_exc ? cause_e'(int_cause) : (irq_take ? CAUSE_IRQ : CAUSE_TMR);
      km_d   = 1'b1;
      ie_d   = 1'b0;
    end

    if (dbl_fault) begin
      code_d = CAUSE_DBL;
      halt_d = 1'b1;
    end

    if (do_exit) begin
      km_d = 1'b0;
      ie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      km_q       <= 1'b1;
      ie_q       <= 1'b0;
      code_q     <= CAUSE_NONE;
      epc_q      <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
      tmr_pend_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      km_q       <= km_d;
      ie_q       <= ie_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      tmr_pend_q <= tmr_pend_d;
      halt_q     <= halt_d;
    end
  end

  always_comb begin
    c0_rdata = '0;
    case (c0_addr)
      C0_STATUS: begin
        c0_rdata[STATUS_KM] = km_q;
        c0_rdata[STATUS_IE] = ie_q;
      end
      C0_CAUSE: begin
        c0_rdata[2:0]           = code_q;
        c0_rdata[CAUSE_IRQ_PEND] = irq_pend;
        c0_rdata[CAUSE_TMR_PEND] = tmr_pend_q;
      end
      C0_EPC:      c0_rdata = epc_q;
      C0_COUNT:    c0_rdata = count_q;
      C0_COMPARE:  c0_rdata = compare_q;
      C0_SCRATCH0: c0_rdata = scratch0_q;
      C0_SCRATCH1: c0_rdata = scratch1_q;
      default:     c0_rdata = '0;
    endcase
  end

  assign irq_ack     = irq_take;
  assign exc_taken   = sync_exc || irq_take || tmr_take;
  assign kernel_mode = km_q;
  assign exc_vector  = EXC_VECTOR;
  assign epc         = epc_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, exceptions, double fault, irq, timer
// and same-cycle priority, with hand-computed expected values.
module tb_cp0_unit;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] pc;
  logic        cause_write;
  logic [2:0]  int_cause;
  logic        exit_kernel;
  logic        write_c0;
  logic [4:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;
  logic        irq;
  logic        irq_ack;
  logic        kernel_mode;
  logic        exc_taken;
  logic [31:0] exc_vector;
  logic [31:0] epc;
  logic        halt;

  int checks;
  int errors;

  cp0_unit #(.DATA_W(32), .EXC_VECTOR(32'h0000_0180), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .pc          (pc),
    .cause_write (cause_write),
    .int_cause   (int_cause),
    .exit_kernel (exit_kernel),
    .write_c0    (write_c0),
    .c0_addr     (c0_addr),
    .c0_wdata    (c0_wdata),
    .c0_rdata    (c0_rdata),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .kernel_mode (kernel_mode),
    .exc_taken   (exc_taken),
    .exc_vector  (exc_vector),
    .epc         (epc),
    .halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    c0_addr = addr;
    #1;
    check_output(tag, c0_rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    cause_write = 1'b0;
    exit_kernel = 1'b0;
    write_c0    = 1'b0;
    int_cause   = 3'd0;
  endtask

  task automatic apply_write(input logic [4:0] addr, input logic [31:0] data);
    idle();
    instr_valid = 1'b1;
    write_c0    = 1'b1;
    c0_addr     = addr;
    c0_wdata    = data;
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    irq = 1'b0;
    pc = '0;
    c0_addr = '0;
    c0_wdata = '0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Reset values
    read_check("rst_status", 5'd0, 32'h1);
    read_check("rst_cause", 5'd1, 32'h0);
    read_check("rst_epc", 5'd2, 32'h0);
    check_output("rst_km", 32'(kernel_mode), 32'h1);
    check_output("rst_halt", 32'(halt), 32'h0);
    check_output("rst_irq_ack", 32'(irq_ack), 32'h0);
    check_output("exc_vector", exc_vector, 32'h0000_0180);

    // Enter user mode with interrupts enabled, then overflow exception
    apply_write(5'd0, 32'h2);
    check_output("user_km", 32'(kernel_mode), 32'h0);
    read_check("user_status", 5'd0, 32'h2);
    instr_valid = 1'b1;
    cause_write = 1'b1;
    int_cause   = 3'b001;
    pc          = 32'h40;
    #1;
    check_output("ovf_exc_taken", 32'(exc_taken), 32'h1);
    check_output("ovf_irq_ack", 32'(irq_ack), 32'h0);
    step();
    idle();
    check_output("ovf_epc", epc, 32'h40);
    read_check("ovf_cause", 5'd1, 32'h1);
    read_check("ovf_status", 5'd0, 32'h1);

    // External irq through the synchronizer
    apply_write(5'd0, 32'h2);
    irq         = 1'b1;
    instr_valid = 1'b1;
    pc          = 32'h80;
    step();
    check_output("irq_sync1_exc", 32'(exc_taken), 32'h0);
    step();
    check_output("irq_take_exc", 32'(exc_taken), 32'h1);
    check_output("irq_take_ack", 32'(irq_ack), 32'h1);
    read_check("irq_pend_cause", 5'd1, 32'h101);
    step();
    check_output("irq_epc", epc, 32'h80);
    read_check("irq_cause", 5'd1, 32'h104);
    check_output("irq_km", 32'(kernel_mode), 32'h1);
    check_output("irq_ack_pulse", 32'(irq_ack), 32'h0);
    step();
    check_output("irq_no_retake", 32'(exc_taken), 32'h0);
    irq = 1'b0;
    idle();
    repeat (3) step();
    read_check("irq_cleared", 5'd1, 32'h004);

    apply_write(5'd6, 32'h1234);
    read_check("scratch1", 5'd6, 32'h1234);
    read_check("unmapped", 5'd7, 32'h0);

    // Timer: COUNT=0, COMPARE=10, drop to user mode and wait for the match
    apply_write(5'd3, 32'h0);
    apply_write(5'd4, 32'd10);
    instr_valid = 1'b1;
    exit_kernel = 1'b1;
    #1;
    check_output("exit_exc_taken", 32'(exc_taken), 32'h0);
    step();
    idle();
    read_check("exit_status", 5'd0, 32'h2);
    repeat (8) step();
    read_check("tmr_not_yet", 5'd1, 32'h004);
    step();
    read_check("tmr_pend", 5'd1, 32'h204);
    instr_valid = 1'b1;
    pc          = 32'hC0;
    #1;
    check_output("tmr_exc_taken", 32'(exc_taken), 32'h1);
    check_output("tmr_irq_ack", 32'(irq_ack), 32'h0);
    step();
    idle();
    check_output("tmr_epc", epc, 32'hC0);
    read_check("tmr_cause", 5'd1, 32'h205);
    apply_write(5'd4, 32'h0);
    read_check("tmr_cleared", 5'd1, 32'h005);
    read_check("count_val", 5'd3, 32'd13);

    // Same cycle: sync exception vs pending irq vs write to EPC
    apply_write(5'd0, 32'h2);
    irq = 1'b1;
    repeat (2) step();
    instr_valid = 1'b1;
    cause_write = 1'b1;
    int_cause   = 3'b011;
    pc          = 32'h100;
    write_c0    = 1'b1;
    c0_addr     = 5'd2;
    c0_wdata    = 32'hDEAD;
    #1;
    check_output("prio_exc_taken", 32'(exc_taken), 32'h1);
    check_output("prio_irq_ack", 32'(irq_ack), 32'h0);
    step();
    idle();
    check_output("prio_epc", epc, 32'h100);
    read_check("prio_cause", 5'd1, 32'h103);
    read_check("prio_status", 5'd0, 32'h1);
    irq = 1'b0;
    repeat (3) step();

    // Double fault in kernel mode
    instr_valid = 1'b1;
    cause_write = 1'b1;
    int_cause   = 3'b011;
    pc          = 32'h200;
    #1;
    check_output("dbl_exc_taken", 32'(exc_taken), 32'h0);
    step();
    idle();
    check_output("dbl_halt", 32'(halt), 32'h1);
    read_check("dbl_cause", 5'd1, 32'h006);
    check_output("dbl_epc", epc, 32'h100);
    apply_write(5'd5, 32'h55);
    read_check("halt_scratch0", 5'd5, 32'h0);
    apply_write(5'd2, 32'h999);
    check_output("halt_epc", epc, 32'h100);
    instr_valid = 1'b1;
    exit_kernel = 1'b1;
    step();
    idle();
    check_output("halt_km", 32'(kernel_mode), 32'h1);
    check_output("halt_sticky", 32'(halt), 32'h1);

    // Asynchronous reset mid-cycle
    reset_n = 1'b0;
    #1;
    check_output("arst_halt", 32'(halt), 32'h0);
    check_output("arst_km", 32'(kernel_mode), 32'h1);
    check_output("arst_epc", epc, 32'h0);
    read_check("arst_cause", 5'd1, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 / exception unit: consumes the decoder's exception and privilege outputs and produces the privilege state and PC redirect.
  - Consumed signals: int_cause, cause_write, exit_kernel, write_c0.
  - Produced: kernel_mode, exception redirect (vector or EPC), and read data for mfc0.
- Holds STATUS, CAUSE, EPC, COUNT, COMPARE and scratch registers.
- Arbitrates synchronous exceptions, an external interrupt and a timer interrupt at instruction boundaries.

Parameters:
- DATA_W, 32, width of c0 registers, pc, wdata and rdata.
- EXC_VECTOR, 32'h0000_0180, PC loaded on any exception entry.
- SYNC_STAGES, 2, irq synchronizer depth (at least 2).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  an instruction at pc commits this cycle.
- pc  in  DATA_W  address of committing instruction.
- cause_write  in  1  decoder flags an exception.
- int_cause  in  3  decoder exception code.
- exit_kernel  in  1  return-from-kernel instruction.
- write_c0  in  1  movc0 instruction.
- c0_addr  in  5  c0 register index (rd field).
- c0_wdata  in  DATA_W  data for movc0.
- c0_rdata  out  DATA_W  combinational read of c0_addr.
- irq  in  1  asynchronous external interrupt, level.
- irq_ack  out  1  one-cycle pulse when the external irq is taken.
- kernel_mode  out  1  1 = kernel privilege.
- exc_taken  out  1  combinational; redirect fetch to EXC_VECTOR and squash the instruction's regwrite/memwrite.
- exc_vector  out  DATA_W  constant EXC_VECTOR.
- epc  out  DATA_W  EPC register, used as return target.
- halt  out  1  sticky double-fault indication.

Behaviour:
- Reset (async, reset_n=0) values:
  - STATUS.km=1, STATUS.ie=0.
  - CAUSE=0, EPC=0, COUNT=0, COMPARE=0, scratch=0.
  - halt=0, irq_ack=0, synchronizer flops=0.
  - Reset asserted mid-operation aborts everything immediately.
- Register map:
  - 0 STATUS: [1] ie, [0] km.
  - 1 CAUSE: [2:0] code, [8] irq_pend, [9] tmr_pend; read-only to software.
  - 2 EPC.
  - 3 COUNT.
  - 4 COMPARE.
  - 5–6 SCRATCH0/1.
  - Other indices read 0; writes to them are ignored.
- Cause codes:
  - 001 overflow, 010 privileged, 011 illegal.
  - 100 external irq, 101 timer, 110 double fault.
- Event priority within one cycle (only when instr_valid=1 and halt=0): cause_write > irq take > timer take > exit_kernel > write_c0. Only the highest-priority event acts.
- Synchronous exception (cause_write=1, km=0):
  - exc_taken=1 in the same cycle.
  - At the next edge: EPC<=pc, CAUSE.code<=int_cause, km<=1, ie<=0.
- Double fault (cause_write=1, km=1):
  - At the next edge: CAUSE.code<=110, halt<=1. EPC is unchanged.
  - exc_taken=0.
  - While halt=1, all state is frozen except COUNT; only reset clears halt.
- External irq:
  - irq passes through SYNC_STAGES flops, then sets irq_pend (level-sensitive, follows the synchronized irq).
  - Taken when irq_pend & ie & !km & instr_valid & !cause_write.
  - On take: exc_taken=1, irq_ack=1 for that cycle, EPC<=pc (instruction squashed, re-executed on return), code<=100, km<=1, ie<=0.
- Timer:
  - COUNT increments by 1 every cycle, wrapping from all-ones to 0.
  - tmr_pend is set on the edge where COUNT==COMPARE and COMPARE!=0; it stays set until software writes COMPARE.
  - Taken with the same conditions as the external irq, at lower priority; code<=101; irq_ack stays 0.
- exit_kernel with km=1: km<=0, ie<=1. Redirect to EPC is done by the datapath jump_reg path; exc_taken=0.
- write_c0:
  - Acts only when km=1; ignored in user mode (the decoder already raises code 010).
  - Writes the register selected by c0_addr at the next edge.
  - STATUS writes take bits [1:0] only.
  - A COUNT write overrides the increment in that cycle.
- Concurrent hardware and software writes: any exception update of EPC/CAUSE/STATUS in the same cycle wins over write_c0.
- c0_rdata is purely combinational and reflects the pre-edge values.

Decomposition:
- cp0_pkg holds:
  - cause code enum (CAUSE_OVF … CAUSE_DBL).
  - register index localparams (C0_STATUS … C0_SCRATCH1).
  - STATUS/CAUSE bit positions.
  - default EXC_VECTOR.
- One sub-module, irq_sync: a SYNC_STAGES flop synchronizer on irq with async reset_n.

Test Plan:
- Reset release, then read addrs 0,1,2 -> rdata 1, 0, 0; kernel_mode=1, halt=0.
- Write STATUS=2'b10 (user mode, ie=1); then cause_write=1, int_cause=001, pc=0x40 -> exc_taken=1 that cycle; next cycle EPC=0x40, CAUSE=001, STATUS=2'b01.
- In kernel mode, cause_write=1, int_cause=011 -> halt=1, CAUSE=110, EPC unchanged, exc_taken=0; further write_c0 ignored until reset.
- User mode, ie=1; irq raised at cycle t -> irq_ack/exc_taken on the first instr_valid at or after t+2; EPC=pc; code=100; irq held during kernel mode is not re-taken.
- COMPARE=10, COUNT=0 -> tmr_pend set after 10 cycles; in user mode with ie=1 it is taken with code 101; a COMPARE write clears tmr_pend.
- Same cycle: cause_write=1 plus pending irq plus write_c0 to EPC -> synchronous exception wins (code from int_cause, EPC=pc); irq_ack=0.
